// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control unit.
package booth_pkg;

  localparam int N_DEF    = 4;
  localparam int CV_W     = 6;
  localparam int CV_RST   = 5;
  localparam int CV_ADD   = 4;
  localparam int CV_SUB   = 3;
  localparam int CV_LOAD  = 2;
  localparam int CV_SHIFT = 1;
  localparam int CV_DC    = 0;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LOAD, S_EVAL, S_ADD, S_SUB, S_SHIFT, S_DONE, S_ERR
  } booth_state_t;

  // Moore control vector for each state; shift and dc always travel together.
  function automatic logic [CV_W-1:0] cv_of(booth_state_t s);
    logic [CV_W-1:0] v;
    v = '0;
    case (s)
      S_CLR:   v[CV_RST]  = 1'b1;
      S_LOAD:  v[CV_LOAD] = 1'b1;
      S_ADD:   v[CV_ADD]  = 1'b1;
      S_SUB:   v[CV_SUB]  = 1'b1;
      S_SHIFT: begin
        v[CV_SHIFT] = 1'b1;
        v[CV_DC]    = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/booth_if.sv
// Control bus between the Booth controller and its datapath / requester.
interface booth_if;
  import booth_pkg::*;

  logic            start;
  logic            Q1;
  logic            Q0;
  logic            count;
  logic [CV_W-1:0] cv;
  logic            busy;
  logic            done;
  logic            err;

  modport master (output start, Q1, Q0, count, input cv, busy, done, err);
  modport slave  (input start, Q1, Q0, count, output cv, busy, done, err);
endinterface

// File: rtl/booth_iter_cnt.sv
// Saturating iteration counter; at_n says N shifts have been issued.
module booth_iter_cnt #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_n
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_n;

  assign w_at_n = (r_cnt == CNT_W'(N));
  assign o_at_n = w_at_n;

  // Count shifts, holding at N so a runaway datapath cannot wrap the check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && !w_at_n) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer with start/busy/done handshake and
// an independent iteration count that cross-checks the datapath counter.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  booth_if.slave bus
);

  booth_state_t    r_state;
  booth_state_t    w_nxt;
  logic [CV_W-1:0] r_cv;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            w_accept;
  logic            w_at_n;

  assign w_accept = (r_state == S_IDLE) && bus.start;

  booth_iter_cnt #(.N(N), .CNT_W(CNT_W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_inc  (r_state == S_SHIFT),
    .o_at_n (w_at_n)
  );

  // Next state: EVAL compares datapath terminal flag against our own count.
  always_comb begin
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_nxt = bus.start ? S_CLR : S_IDLE;
      S_CLR:   w_nxt = S_LOAD;
      S_LOAD:  w_nxt = S_EVAL;
      S_EVAL: begin
        if (bus.count)   w_nxt = w_at_n ? S_DONE : S_ERR;
        else if (w_at_n) w_nxt = S_ERR;
        else begin
          case ({bus.Q1, bus.Q0})
            2'b10:   w_nxt = S_SUB;
            2'b01:   w_nxt = S_ADD;
            default: w_nxt = S_SHIFT;
          endcase
        end
      end
      S_ADD:   w_nxt = S_SHIFT;
      S_SUB:   w_nxt = S_SHIFT;
      S_SHIFT: w_nxt = S_EVAL;
      S_DONE:  w_nxt = S_IDLE;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output is glitch-free and aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cv    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cv    <= cv_of(w_nxt);
      r_busy  <= (w_nxt != S_IDLE) && (w_nxt != S_ERR);
      r_done  <= (w_nxt == S_DONE);
      if (w_nxt == S_ERR) r_err <= 1'b1;
      else if (w_accept)  r_err <= 1'b0;
    end
  end

  assign bus.cv   = r_cv;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl: a behavioural datapath drives Q1/Q0/count,
// expectations are derived from the Booth recoding rules per operation.
module tb_booth_ctrl;
  import booth_pkg::*;

  localparam int NN   = 4;
  localparam int MAXC = 32;

  localparam logic [5:0] B_RST = 6'b100000;
  localparam logic [5:0] B_ADD = 6'b010000;
  localparam logic [5:0] B_SUB = 6'b001000;
  localparam logic [5:0] B_LD  = 6'b000100;
  localparam logic [5:0] B_SH  = 6'b000011;

  typedef struct packed {
    logic [MAXC-1:0][5:0] seq;
    int                   len;
    bit                   is_err;
  } exp_t;

  typedef struct packed {
    logic [3:0] m;
    int         k;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  booth_if bus();

  booth_ctrl #(.N(NN), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  cfg_t cfgq[$];
  int   ops_fin = 0;

  function automatic void chk(bit ok, string name, int act, int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Expected cv trace from the Booth rules: each iteration is an evaluate
  // cycle, an optional add/sub chosen by the bit pair, then a shift.
  function automatic exp_t build_exp(logic [3:0] m, int k);
    exp_t e;
    logic q1, q0;
    e = '0;
    e.seq[0] = B_RST;
    e.seq[1] = B_LD;
    e.len = 2;
    for (int i = 0; i <= NN; i++) begin
      e.seq[e.len] = 6'b0; e.len++;
      if ((i >= k) || (i == NN)) begin
        e.seq[e.len] = 6'b0; e.len++;
        e.is_err = !((i >= k) && (i == NN));
        break;
      end
      q1 = m[i];
      q0 = (i == 0) ? 1'b0 : m[i-1];
      if (q1 & !q0) begin e.seq[e.len] = B_SUB; e.len++; end
      if (!q1 & q0) begin e.seq[e.len] = B_ADD; e.len++; end
      e.seq[e.len] = B_SH; e.len++;
    end
    return e;
  endfunction

  // Behavioural datapath: Q bits step down one per shift, counter terminal at k.
  cfg_t cur_cfg = '{m: 4'b0, k: NN};
  int   shifts = 0;
  initial begin
    bus.Q1 = 1'b0; bus.Q0 = 1'b0; bus.count = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) shifts = 0;
      else begin
        if (bus.cv[CV_RST]) begin
          shifts = 0;
          if (cfgq.size() > 0) cur_cfg = cfgq.pop_front();
        end
        if (bus.cv[CV_SHIFT]) shifts++;
      end
      bus.Q1    = (shifts < NN) ? cur_cfg.m[shifts] : cur_cfg.m[NN-1];
      bus.Q0    = (shifts == 0) ? 1'b0 : ((shifts - 1 < NN) ? cur_cfg.m[shifts-1] : cur_cfg.m[NN-1]);
      bus.count = (shifts >= cur_cfg.k);
    end
  end

  // Monitor: an op opens on dp_rst, closes on done or err; then compare.
  bit                   coll = 0;
  bit                   post_err = 0;
  bit                   busy_ok;
  int                   clen;
  logic [MAXC-1:0][5:0] got;
  exp_t                 ce;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin coll = 0; post_err = 0; continue; end
      if (!coll) begin
        if (post_err) begin
          chk(bus.err == 1'b1, "err_sticky", int'(bus.err), 1);
          chk(bus.cv == 6'b0 && !bus.busy, "idle_after_err", int'(bus.cv), 0);
          post_err = 0;
        end
        if (bus.cv == B_RST) begin
          coll = 1; clen = 0; busy_ok = 1; got = '0;
          chk(bus.err == 1'b0, "err_clr_on_start", int'(bus.err), 0);
          if (sbq.size() == 0) begin
            chk(1'b0, "unexpected_op", 1, 0);
            ce = build_exp(4'b0, NN);
          end else ce = sbq.pop_front();
        end else begin
          chk(bus.done == 1'b0 && bus.cv == 6'b0, "quiet_idle", int'({bus.done, bus.cv}), 0);
        end
      end
      if (coll) begin
        got[clen] = bus.cv;
        clen++;
        if (bus.done || bus.err) begin
          if (bus.busy != bus.done) busy_ok = 0;
          coll = 0;
          chk(clen == ce.len, "latency", clen, ce.len);
          chk(bus.err == ce.is_err && bus.done == !ce.is_err, "outcome", int'({bus.err, bus.done}), int'({ce.is_err, !ce.is_err}));
          for (int j = 0; j < MAXC; j++)
            if (j < clen && j < ce.len && got[j] != ce.seq[j]) begin
              chk(1'b0, "cv_seq", int'(got[j]), int'(ce.seq[j]));
              break;
            end
          chk(busy_ok, "busy", 0, 1);
          post_err = bus.err;
          ops_fin++;
        end else begin
          if (!bus.busy) busy_ok = 0;
          if (bus.cv[CV_ADD] && bus.cv[CV_SUB]) chk(1'b0, "add_sub_both", 1, 0);
          if (clen >= MAXC) begin
            chk(1'b0, "op_timeout", clen, ce.len);
            coll = 0;
            ops_fin++;
          end
        end
      end
    end
  end

  task automatic queue_op(logic [3:0] m, int k);
    cfg_t c;
    c.m = m; c.k = k;
    cfgq.push_back(c);
    sbq.push_back(build_exp(m, k));
  endtask

  task automatic wait_ops(int target);
    int n = 0;
    while (ops_fin < target && n < 200) begin @(negedge clk); n++; end
    if (ops_fin < target) chk(1'b0, "wait_timeout", ops_fin, target);
  endtask

  task automatic run_op(logic [3:0] m, int k, bit poke);
    int t;
    t = ops_fin + 1;
    queue_op(m, k);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    if (poke) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end
    wait_ops(t);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(bus.cv == 6'b0 && !bus.busy && !bus.done && !bus.err, "reset_state",
        int'({bus.cv, bus.busy, bus.done, bus.err}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(4'b0000, NN, 0);
    run_op(4'b0101, NN, 0);
    run_op(4'b1111, NN, 0);
    run_op(4'b0110, NN, 1);
    run_op(4'b0000, 3, 0);
    run_op(4'b1010, 99, 0);
    run_op(4'b0011, 1, 0);
    run_op(4'b0000, NN, 0);

    for (int i = 0; i < 16; i++) begin
      int kr;
      kr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : NN;
      run_op(4'($urandom_range(0, 15)), kr, 0);
    end

    // back-to-back with start held high
    n = ops_fin;
    for (int i = 0; i < 3; i++) queue_op(4'b0000, NN);
    @(negedge clk); bus.start = 1'b1;
    wait_ops(n + 3);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a shift
    queue_op(4'b0000, NN);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (!bus.cv[CV_SHIFT] && n < 40) begin @(negedge clk); n++; end
    chk(bus.cv == B_SH, "reach_shift", int'(bus.cv), int'(B_SH));
    rst = 1'b1;
    #1;
    chk(bus.cv == 6'b0 && !bus.busy && !bus.done && !bus.err, "async_rst",
        int'({bus.cv, bus.busy, bus.done, bus.err}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.cv == 6'b0 && !bus.busy, "idle_after_rst", int'({bus.cv, bus.busy}), 0);

    run_op(4'b1001, NN, 0);

    chk(sbq.size() == 0, "sb_empty", sbq.size(), 0);
    chk(cfgq.size() == 0, "cfg_empty", cfgq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
